// File: rtl/sipo_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer_pkg
// Description : Shared types and helpers for the SIPO deserializer slice.
//               - state_t       : frame FSM state encoding (IDLE / SHIFT)
//               - DEFAULT_WIDTH : default frame width, matches the 4-bit
//                                 enable-loaded register fed by word_out
//               - cnt_width()   : width of a counter holding 0..w
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_deserializer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to count from 0 up to and including w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer_if
// Description : Frame/bit handshake and parallel-word bundle of the
//               deserializer.
//               Producer -> deserializer : frame_start, bit_valid, serial_in
//               Deserializer -> consumer : word_out, word_valid, busy,
//                                          bit_count, frame_err
//               modport master : the serial source / observer side
//               modport slave  : the deserializer side
// Revision    : 1.0 - initial release
// ============================================================================
interface sipo_deserializer_if
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  localparam int CW = cnt_width(WIDTH);

  logic             frame_start;
  logic             bit_valid;
  logic             serial_in;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             busy;
  logic [CW-1:0]    bit_count;
  logic             frame_err;

  modport master (
    output frame_start,
    output bit_valid,
    output serial_in,
    input  word_out,
    input  word_valid,
    input  busy,
    input  bit_count,
    input  frame_err
  );

  modport slave (
    input  frame_start,
    input  bit_valid,
    input  serial_in,
    output word_out,
    output word_valid,
    output busy,
    output bit_count,
    output frame_err
  );

endinterface
`default_nettype wire

// File: rtl/sipo_shift_core.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shift_core
// Description : WIDTH-bit serial-in shift register with selectable direction.
//               MSB_FIRST=1 shifts toward the MSB so the first bit ends up in
//               bit WIDTH-1; MSB_FIRST=0 shifts toward the LSB so the first
//               bit ends up in bit 0.
// Ports       : clk        rising-edge clock
//               reset      asynchronous active-low reset, clears the register
//               i_clear    discard contents (takes priority over old data)
//               i_shift_en shift i_serial in this cycle
//               i_serial   serial data bit
//               o_shifted  combinational view of the register with i_serial
//                          shifted in (used to capture a completing word)
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift_core
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_clear,
  input  wire logic             i_shift_en,
  input  wire logic             i_serial,
  output logic      [WIDTH-1:0] o_shifted
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_from_data;  // current contents with the new bit added
  logic [WIDTH-1:0] w_from_zero;  // empty register with the new bit added

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_from_data = {r_data[WIDTH-2:0], i_serial};
      assign w_from_zero = {{(WIDTH-1){1'b0}}, i_serial};
    end else begin : g_lsb_first
      assign w_from_data = {i_serial, r_data[WIDTH-1:1]};
      assign w_from_zero = {i_serial, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  // Clear together with shift means the incoming bit is the first bit of
  // a fresh frame, so it is shifted into an empty register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else if (i_clear) begin
      r_data <= i_shift_en ? w_from_zero : '0;
    end else if (i_shift_en) begin
      r_data <= w_from_data;
    end
  end

  assign o_shifted = w_from_data;

endmodule
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer
// Description : Serial-in / parallel-out frame capture. Collects WIDTH bits
//               per frame, presents the word on word_out with a one-cycle
//               word_valid pulse, and flags frames aborted by frame_start.
// Ports       : clk    rising-edge clock
//               reset  asynchronous active-low reset
//               bus    sipo_deserializer_if.slave:
//                        frame_start, bit_valid, serial_in (in)
//                        word_out, word_valid, busy, bit_count, frame_err (out)
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input wire logic          clk,
  input wire logic          reset,
  sipo_deserializer_if.slave bus
);

  localparam int            CW         = cnt_width(WIDTH);
  localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_one      = CW'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_word_out;
  logic             r_word_valid;
  logic             r_busy;
  logic [CW-1:0]    r_bit_count;
  logic             r_frame_err;

  logic             w_in_shift;
  logic             w_complete;
  logic             w_core_clear;
  logic             w_core_shift;
  logic [WIDTH-1:0] w_shifted;

  assign w_in_shift = (r_state == ST_SHIFT);

  // The edge that accepts bit WIDTH completes the word, even if frame_start
  // arrives in the same cycle.
  assign w_complete = w_in_shift && bus.bit_valid && (r_bit_count == c_last_bit);

  // Any frame_start or completion empties the shift register. A bit is
  // shifted in when in SHIFT, or when it arrives with frame_start from IDLE;
  // the completing bit goes straight to word_out instead, so a colliding
  // frame_start begins an empty frame.
  assign w_core_clear = bus.frame_start || w_complete;
  assign w_core_shift = bus.bit_valid && (w_in_shift || bus.frame_start) && !w_complete;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_core (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_core_clear),
    .i_shift_en (w_core_shift),
    .i_serial   (bus.serial_in),
    .o_shifted  (w_shifted)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_bit_count  <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.frame_start) begin
            r_state     <= ST_SHIFT;
            r_busy      <= 1'b1;
            r_bit_count <= bus.bit_valid ? c_one : '0;
          end
        end
        ST_SHIFT: begin
          if (w_complete) begin
            r_word_out   <= w_shifted;
            r_word_valid <= 1'b1;
            r_bit_count  <= '0;
            if (bus.frame_start) begin
              // New frame begins empty; the colliding bit belonged to the old word.
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (bus.frame_start) begin
            // Restart: only a frame that already holds bits counts as aborted.
            r_frame_err <= (r_bit_count != '0);
            r_bit_count <= bus.bit_valid ? c_one : '0;
          end else if (bus.bit_valid) begin
            r_bit_count <= r_bit_count + c_one;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.word_out   = r_word_out;
  assign bus.word_valid = r_word_valid;
  assign bus.busy       = r_busy;
  assign bus.bit_count  = r_bit_count;
  assign bus.frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deserializer
// Description : Directed bench for sipo_deserializer. Two instances share one
//               stimulus stream: dut_m (MSB_FIRST=1) and dut_l (MSB_FIRST=0).
//               A 4-bit enable-loaded register model hangs off dut_m.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;
  import sipo_deserializer_pkg::*;

  logic clk;
  logic reset;
  logic frame_start;
  logic bit_valid;
  logic serial_in;
  logic [3:0] reg_q;

  int total;
  int bad;

  sipo_deserializer_if #(.WIDTH(4)) if_m ();
  sipo_deserializer_if #(.WIDTH(4)) if_l ();

  assign if_m.frame_start = frame_start;
  assign if_m.bit_valid   = bit_valid;
  assign if_m.serial_in   = serial_in;
  assign if_l.frame_start = frame_start;
  assign if_l.bit_valid   = bit_valid;
  assign if_l.serial_in   = serial_in;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (if_m.slave)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (if_l.slave)
  );

  // Downstream register: d = word_out, enable = word_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               reg_q <= 4'h0;
    else if (if_m.word_valid) reg_q <= if_m.word_out;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fs;
    logic       bv;
    logic       si;
    logic       wv;
    logic [3:0] word_m;
    logic [3:0] word_l;
    logic       busy;
    logic [2:0] cnt;
    logic       err;
    logic [3:0] q;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one edge, sample 1 time unit after it.
  task automatic step(input logic fs, input logic bv, input logic si);
    frame_start = fs;
    bit_valid   = bv;
    serial_in   = si;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic wv, input logic [3:0] wm,
                           input logic [3:0] wl, input logic bz, input logic [2:0] cnt,
                           input logic err);
    check({tag, ".word_valid"}, int'(if_m.word_valid), int'(wv));
    check({tag, ".word_out_m"}, int'(if_m.word_out),   int'(wm));
    check({tag, ".word_out_l"}, int'(if_l.word_out),   int'(wl));
    check({tag, ".busy"},       int'(if_m.busy),       int'(bz));
    check({tag, ".bit_count"},  int'(if_m.bit_count),  int'(cnt));
    check({tag, ".frame_err"},  int'(if_m.frame_err),  int'(err));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    serial_in   = 1'b0;

    // fs bv si | wv word_m word_l busy cnt err q
    // back-to-back frames 1,1,0,0 then 0,1,1,0
    vecs[0]  = '{1,1,1, 0,4'h0,4'h0,1,3'd1,0,4'h0};
    vecs[1]  = '{0,1,1, 0,4'h0,4'h0,1,3'd2,0,4'h0};
    vecs[2]  = '{0,1,0, 0,4'h0,4'h0,1,3'd3,0,4'h0};
    vecs[3]  = '{0,1,0, 1,4'hC,4'h3,0,3'd0,0,4'h0};
    vecs[4]  = '{1,1,0, 0,4'hC,4'h3,1,3'd1,0,4'hC};
    vecs[5]  = '{0,1,1, 0,4'hC,4'h3,1,3'd2,0,4'hC};
    vecs[6]  = '{0,1,1, 0,4'hC,4'h3,1,3'd3,0,4'hC};
    vecs[7]  = '{0,1,0, 1,4'h6,4'h6,0,3'd0,0,4'hC};
    // bit_valid in IDLE without frame_start is ignored
    vecs[8]  = '{0,1,1, 0,4'h6,4'h6,0,3'd0,0,4'h6};
    // abort: start, 1,1, restart carrying bit 0, then 0,0,1
    vecs[9]  = '{1,0,0, 0,4'h6,4'h6,1,3'd0,0,4'h6};
    vecs[10] = '{0,1,1, 0,4'h6,4'h6,1,3'd1,0,4'h6};
    vecs[11] = '{0,1,1, 0,4'h6,4'h6,1,3'd2,0,4'h6};
    vecs[12] = '{1,1,0, 0,4'h6,4'h6,1,3'd1,1,4'h6};
    vecs[13] = '{0,1,0, 0,4'h6,4'h6,1,3'd2,0,4'h6};
    vecs[14] = '{0,1,0, 0,4'h6,4'h6,1,3'd3,0,4'h6};
    vecs[15] = '{0,1,1, 1,4'h1,4'h8,0,3'd0,0,4'h6};
    // frame_start with an empty frame restarts silently
    vecs[16] = '{1,0,0, 0,4'h1,4'h8,1,3'd0,0,4'h1};
    vecs[17] = '{1,0,0, 0,4'h1,4'h8,1,3'd0,0,4'h1};
    // collision: 4th bit together with frame_start, bits 1,0,0,1
    vecs[18] = '{0,1,1, 0,4'h1,4'h8,1,3'd1,0,4'h1};
    vecs[19] = '{0,1,0, 0,4'h1,4'h8,1,3'd2,0,4'h1};
    vecs[20] = '{0,1,0, 0,4'h1,4'h8,1,3'd3,0,4'h1};
    vecs[21] = '{1,1,1, 1,4'h9,4'h9,1,3'd0,0,4'h1};
    vecs[22] = '{0,1,0, 0,4'h9,4'h9,1,3'd1,0,4'h9};
    vecs[23] = '{1,0,0, 0,4'h9,4'h9,1,3'd0,1,4'h9};
    vecs[24] = '{0,0,0, 0,4'h9,4'h9,1,3'd0,0,4'h9};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0);
    check("reset.q", int'(reg_q), 0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven sequences
    for (int i = 0; i < 25; i++) begin
      step(vecs[i].fs, vecs[i].bv, vecs[i].si);
      check_all($sformatf("vec%0d", i), vecs[i].wv, vecs[i].word_m, vecs[i].word_l,
                vecs[i].busy, vecs[i].cnt, vecs[i].err);
      check($sformatf("vec%0d.q", i), int'(reg_q), int'(vecs[i].q));
    end

    // Gapped bits 0,1,0,1 with three idle cycles between bits
    step(1, 1, 0);
    check("gap.cnt1", int'(if_m.bit_count), 1);
    for (int b = 1; b < 4; b++) begin
      for (int g = 0; g < 3; g++) begin
        step(0, 0, 1);
        check($sformatf("gap.hold%0d_%0d", b, g), int'(if_m.bit_count), b);
        check($sformatf("gap.busy%0d_%0d", b, g), int'(if_m.busy), 1);
      end
      step(0, 1, (b % 2 == 1) ? 1'b1 : 1'b0);
      if (b < 3) check($sformatf("gap.cnt%0d", b + 1), int'(if_m.bit_count), b + 1);
    end
    check_all("gap.done", 1'b1, 4'h5, 4'hA, 1'b0, 3'd0, 1'b0);
    step(0, 0, 0);
    check("gap.pulse_end", int'(if_m.word_valid), 0);
    check("gap.q", int'(reg_q), 5);

    // Asynchronous reset mid-frame after two bits
    step(1, 1, 1);
    step(0, 1, 0);
    check("rst.cnt_before", int'(if_m.bit_count), 2);
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all("rst.async", 1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Full frame 1,0,1,1 after release
    step(1, 1, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    check("post.cnt3", int'(if_m.bit_count), 3);
    step(0, 1, 1);
    check_all("post.done", 1'b1, 4'hB, 4'hD, 1'b0, 3'd0, 1'b0);
    step(0, 0, 0);
    check("post.pulse_end", int'(if_m.word_valid), 0);
    check("post.q", int'(reg_q), 11);
    step(0, 0, 0);
    check("post.hold_word", int'(if_m.word_out), 11);
    check("post.hold_q", int'(reg_q), 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in/parallel-out capture stage that sits directly upstream of the team's 4-bit enable-loaded register.
- Collects WIDTH serial bits per frame and presents the assembled word on word_out.
- Pulses word_valid for one cycle per completed word, so word_out/word_valid wire straight to the register's d/enable.
- Flags frames that are restarted before completion.

Parameters:
- WIDTH, 4, bits per frame and width of word_out (legal range 2..16).
- MSB_FIRST, 1, 1: first received bit lands in word_out[WIDTH-1]; 0: first bit lands in word_out[0].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- frame_start  input  1  single-cycle strobe marking the start of a new frame
- bit_valid  input  1  serial_in carries a valid bit this cycle
- serial_in  input  1  serial data bit
- word_out  output  WIDTH  last completed word; held until the next completion
- word_valid  output  1  one-cycle pulse, high in the cycle word_out updates
- busy  output  1  high while a frame is in progress (state SHIFT)
- bit_count  output  $clog2(WIDTH+1)  bits accepted in the current frame
- frame_err  output  1  one-cycle pulse when an in-progress frame is aborted by frame_start

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-frame):
  - state=IDLE.
  - word_out=0, word_valid=0, busy=0, bit_count=0, frame_err=0.
  - Internal shift register is cleared.
  - Release is synchronous to clk; the first edge with reset=1 evaluates inputs normally.
- States: IDLE, SHIFT. All outputs are registered.
- IDLE:
  - bit_valid is ignored unless frame_start=1 in the same cycle.
  - frame_start=1 -> SHIFT, bit_count=0.
  - frame_start=1 with bit_valid=1 -> that serial_in bit is the first frame bit; bit_count=1 next cycle.
- SHIFT:
  - Each cycle with bit_valid=1 shifts serial_in in per MSB_FIRST and increments bit_count.
  - Cycles with bit_valid=0 hold all state; there is no timeout.
- Completion: on the edge that accepts bit WIDTH:
  - word_out <= assembled word.
  - word_valid=1 for exactly that following cycle.
  - state -> IDLE, bit_count -> 0, busy -> 0.
  - Latency: word_out/word_valid valid in the cycle immediately after the last bit's sampling edge.
- Restart: frame_start=1 while in SHIFT with bit_count>0:
  - Discard the partial word; frame_err pulses for one cycle.
  - Stay in SHIFT and reset bit_count to 0, or to 1 if bit_valid=1 in that cycle (that bit becomes the first bit of the new frame).
  - word_out is unchanged.
- frame_start in SHIFT with bit_count=0: restarts silently, with no frame_err.
- Completion collides with frame_start:
  - The last bit completes the word first (word_valid=1).
  - Then treat frame_start as a new frame from IDLE: next state SHIFT, bit_count=0, no frame_err.
  - Only serial_in counts toward the old word.
- word_out is never cleared after a completion, only by reset.
- bit_count saturation: bit_count never exceeds WIDTH-1 in SHIFT; reaching WIDTH triggers completion.

Decomposition:
- Shared package holds:
  - State enum (IDLE, SHIFT).
  - Function computing the count width, clog2(WIDTH+1).
  - Localparam for the default WIDTH=4, matching the downstream register.
- One natural sub-module: sipo_shift_core.
  - Contents: the WIDTH-bit shift register with MSB_FIRST direction, a clear input, and a shift-enable input.
  - The FSM, counter and output registers stay in the top module.

Test Plan:
- Reset: assert reset=0 mid-frame after 2 bits -> all outputs 0 immediately (before the next edge); after release, a full frame 1,0,1,1 (MSB_FIRST=1) -> word_out=4'b1011, word_valid pulse.
- Back-to-back frames: frame_start with bits 1,1,0,0 then immediately frame_start with bits 0,1,1,0 -> word_out=4'hC then 4'h6; exactly two single-cycle word_valid pulses, busy drops for at most one cycle between frames.
- Gapped bits: bits 0,1,0,1 with bit_valid low for 3 cycles between each -> bit_count steps 1,2,3, word_out=4'h5 one cycle after the 4th bit; with MSB_FIRST=0 the same stream gives 4'hA.
- Abort: frame_start, bits 1,1; then frame_start with bit_valid=1, serial_in=0, then bits 0,0,1 -> frame_err one pulse at the restart; word_out=4'h1; no word_valid for the aborted frame.
- Collision: 4th bit accepted in the same cycle as frame_start (bits 1,0,0,1) -> word_out=4'h9, word_valid=1, next cycle busy=1, bit_count=0, frame_err=0.
- Downstream hookup: connect to the 4-bit register (d=word_out, enable=word_valid) -> register q follows each completed word one cycle after word_valid and holds between frames.
